// File: rtl/d16_bus_pkg.sv
// Shared bus definitions for the DRAM arbiter initiators: address/data widths
// and the frame-buffer reader state encoding.
package d16_bus_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } fb_state_t;
endpackage

// File: rtl/fb_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible on dout
// whenever the FIFO is non-empty and reads as zero when empty.
module fb_fifo
  import d16_bus_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush && (count != FULL);
  assign do_pop  = pop && !flush && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (!do_push && do_pop) count <= count - (PW+1)'(1);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fb_reader.sv
// Read-only DRAM streaming master: fetches one linear frame of words through
// the arbiter's port 1 into a small FIFO drained by the pixel serialiser.
module fb_reader
  import d16_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 24'h000000,
  parameter int                FRAME_WORDS = 9600,
  parameter int                FIFO_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              frame_done,
  output logic [ADDR_W-1:0] addr1,
  output logic              req_read1,
  input  logic [DATA_W-1:0] data1,
  input  logic              data_valid1
);
  localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(FRAME_WORDS);

  fb_state_t         state;
  fb_state_t         state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] rem;
  logic              discard;
  logic [CW-1:0]     count;
  logic              empty;
  logic              can_req;
  logic              accept;
  logic              keep;

  // A request is only issued when the FIFO has a free slot for the returning word.
  assign can_req = enable && !frame_done && (count < DEPTH_CNT);
  assign accept  = (state == REQ) && data_valid1;
  assign keep    = accept && !discard && !frame_start;

  fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (keep),
    .pop   (pix_pop),
    .din   (data1),
    .dout  (pix_data),
    .count (count),
    .empty (empty)
  );

  assign pix_valid = !empty;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (!frame_start && can_req) state_next = REQ;
      REQ:  if (data_valid1) state_next = GAP;
      GAP: begin
        if (frame_start)     state_next = IDLE;
        else if (rem == '0)  state_next = DONE;
        else if (can_req)    state_next = REQ;
        else                 state_next = IDLE;
      end
      DONE: if (frame_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_read1  <= 1'b0;
      addr1      <= BASE_ADDR;
      ptr        <= BASE_ADDR;
      rem        <= FRAME_CNT;
      discard    <= 1'b0;
      underflow  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      req_read1  <= (state_next == REQ);
      frame_done <= (state_next == DONE);
      if (state != REQ && state_next == REQ) addr1 <= ptr;
      // A restart mid-request keeps addr1/req_read1 steady and drops the reply.
      if (frame_start) begin
        ptr       <= BASE_ADDR;
        rem       <= FRAME_CNT;
        underflow <= 1'b0;
        discard   <= (state == REQ) && !data_valid1;
      end else begin
        if (pix_pop && empty) underflow <= 1'b1;
        if (keep) begin
          ptr <= ptr + ADDR_W'(1);
          rem <= rem - ADDR_W'(1);
        end
        if (accept) discard <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader: latency-randomised arbiter, queue-based frame model,
// per-cycle output comparison plus directed scenarios with literal expectations.
module tb_fb_reader;
  localparam logic [23:0] BASE  = 24'h000020;
  localparam int          FW    = 10;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, enable, frame_start, pix_pop, data_valid1;
  logic [31:0] data1, pix_data;
  logic [23:0] addr1;
  logic        req_read1, pix_valid, underflow, frame_done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] q[$];
  int          fetched;
  logic        m_req, m_uf, m_done, m_drop;
  logic [23:0] m_addr;
  bit          started = 1'b0;

  // Arbiter model state
  int   arb_wait, arb_lat, lat_min, lat_max;
  logic prev_req;
  int   rises, total_rises;

  always #5 clk = ~clk;

  fb_reader #(.BASE_ADDR(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .pix_pop(pix_pop), .pix_data(pix_data), .pix_valid(pix_valid),
    .underflow(underflow), .frame_done(frame_done), .addr1(addr1),
    .req_read1(req_read1), .data1(data1), .data_valid1(data_valid1)
  );

  function automatic logic [31:0] fval(input logic [23:0] a);
    return {8'hA5, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model from pre-edge values, then drive the arbiter.
  task automatic cycle();
    logic        s_rst = rst;
    logic        s_en  = enable;
    logic        s_fs  = frame_start;
    logic        s_pop = pix_pop;
    logic        s_dv  = data_valid1;
    logic        s_req = req_read1;
    logic        nreq, nd;
    @(posedge clk);
    if (s_rst) begin
      q.delete();
      fetched = 0; m_req = 1'b0; m_uf = 1'b0; m_done = 1'b0; m_drop = 1'b0;
      m_addr = BASE; started = 1'b1;
    end else begin
      nd = !s_fs && (fetched == FW) && !s_req;
      if (s_req) nreq = !s_dv;
      else nreq = s_en && !s_fs && (q.size() < DEPTH) && (fetched < FW) && !m_done;
      if (!s_req && nreq) m_addr = BASE + 24'(fetched);
      if (s_fs) begin
        q.delete();
        m_uf = 1'b0;
      end else if (s_pop) begin
        if (q.size() != 0) void'(q.pop_front());
        else m_uf = 1'b1;
      end
      if (s_req && s_dv) begin
        if (!m_drop && !s_fs) begin
          chk("no_push_when_full", q.size() < DEPTH, 1'b1);
          q.push_back(fval(BASE + 24'(fetched)));
          fetched++;
        end
        m_drop = 1'b0;
      end else if (s_req && s_fs) begin
        m_drop = 1'b1;
      end
      if (s_fs) fetched = 0;
      m_req = nreq;
      m_done = nd;
    end
    @(negedge clk);
    #1;
    if (req_read1 && !prev_req) begin
      rises++;
      total_rises++;
    end
    prev_req = req_read1;
    if (s_rst || data_valid1) begin
      data_valid1 = 1'b0;
      arb_wait = 0;
      data1 = $urandom;
    end else if (req_read1) begin
      if (arb_wait == 0) arb_lat = $urandom_range(lat_max, lat_min);
      arb_wait++;
      if (arb_wait >= arb_lat) begin
        data_valid1 = 1'b1;
        data1 = fval(addr1);
      end
    end else begin
      arb_wait = 0;
      data1 = $urandom;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("req_read1", req_read1, m_req);
      if (m_req) chk("addr1", addr1, m_addr);
      chk("pix_valid", pix_valid, q.size() != 0);
      if (q.size() != 0) chk("pix_data", pix_data, q[0]);
      else chk("pix_data_empty", pix_data, 32'h0);
      chk("underflow", underflow, m_uf);
      chk("frame_done", frame_done, m_done);
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, req_read1, 1'b0);
    chk({tag, "_addr"}, addr1, BASE);
    chk({tag, "_valid"}, pix_valid, 1'b0);
    chk({tag, "_data"}, pix_data, 32'h0);
    chk({tag, "_uf"}, underflow, 1'b0);
    chk({tag, "_done"}, frame_done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; pix_pop = 1'b0;
    data_valid1 = 1'b0; data1 = 32'h0;
    arb_wait = 0; arb_lat = 3; lat_min = 3; lat_max = 3;
    prev_req = 1'b0; rises = 0; total_rises = 0;
    cycle();
    cycle();
    check_reset_values("reset");
    rst = 1'b0;
    cycle();

    // Fill: no pops, FIFO stops requests once full
    enable = 1'b1;
    rises = 0;
    repeat (60) cycle();
    chk("fill_requests", rises, 4);
    chk("fill_head", pix_data, fval(BASE));
    rises = 0;
    pix_pop = 1'b1;
    cycle();
    pix_pop = 1'b0;
    chk("pop_next_head", pix_data, fval(BASE + 24'd1));
    repeat (30) cycle();
    chk("one_refill_request", rises, 1);

    // Drain to end of frame
    for (int i = 0; i < 400 && !frame_done; i++) begin
      pix_pop = pix_valid && ($urandom_range(1, 0) == 1);
      cycle();
    end
    pix_pop = 1'b0;
    chk("frame_done_set", frame_done, 1'b1);
    chk("total_requests", total_rises, FW);
    rises = 0;
    for (int i = 0; i < 40 && pix_valid; i++) begin
      pix_pop = 1'b1;
      cycle();
    end
    pix_pop = 1'b0;
    repeat (10) cycle();
    chk("no_extra_request", rises, 0);
    chk("drained", pix_valid, 1'b0);

    // Underflow is sticky until frame_start
    pix_pop = 1'b1;
    cycle();
    pix_pop = 1'b0;
    chk("underflow_set", underflow, 1'b1);
    repeat (5) cycle();
    chk("underflow_sticky", underflow, 1'b1);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("underflow_cleared", underflow, 1'b0);
    chk("frame_done_cleared", frame_done, 1'b0);

    // Restart while a request is outstanding at BASE+5
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 300 && !(req_read1 && addr1 == BASE + 24'd5); i++) begin
      pix_pop = pix_valid;
      cycle();
    end
    pix_pop = 1'b0;
    chk("reached_addr5", req_read1 && (addr1 == BASE + 24'd5), 1'b1);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("req_held_after_fs", req_read1, 1'b1);
    chk("addr_held_after_fs", addr1, BASE + 24'd5);
    chk("flushed_after_fs", pix_valid, 1'b0);
    for (int i = 0; i < 20 && req_read1; i++) cycle();
    chk("dropped_word", pix_valid, 1'b0);
    for (int i = 0; i < 10 && !req_read1; i++) cycle();
    chk("restart_req", req_read1, 1'b1);
    chk("restart_addr", addr1, BASE);
    chk("restart_empty", pix_valid, 1'b0);

    // Enable dropped mid-request
    enable = 1'b0;
    for (int i = 0; i < 20 && req_read1; i++) cycle();
    chk("inflight_delivered", pix_valid, 1'b1);
    chk("inflight_data", pix_data, fval(BASE));
    rises = 0;
    repeat (20) cycle();
    chk("no_req_disabled", rises, 0);
    enable = 1'b1;
    for (int i = 0; i < 5 && !req_read1; i++) cycle();
    chk("req_resumes", req_read1, 1'b1);
    chk("resume_addr", addr1, BASE + 24'd1);

    // Reset during a pending request, then a stray data_valid1
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_values("mid_req_reset");
    enable = 1'b0;
    data_valid1 = 1'b1;
    data1 = 32'hDEADBEEF;
    cycle();
    chk("stray_dv_valid", pix_valid, 1'b0);
    chk("stray_dv_req", req_read1, 1'b0);

    // Randomised traffic
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 2500; i++) begin
      enable      = ($urandom_range(99, 0) < 85);
      pix_pop     = ($urandom_range(99, 0) < 40);
      frame_start = ($urandom_range(99, 0) < 2);
      rst         = ($urandom_range(999, 0) < 3);
      cycle();
    end
    rst = 1'b0; frame_start = 1'b0; pix_pop = 1'b0; enable = 1'b0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fb_reader.md
# fb_reader

Read-only DRAM streaming master for the video path. It drives the bus arbiter's port 1 (`addr1`/`req_read1` in, `data1`/`data_valid1` out), which is the read-only initiator side opposite the arbiter's responder, and it is unused in the current top level. It fetches a linear frame of 32-bit words starting at a base address into a small FIFO. A pixel/serialiser stage (the NTSC generator side, same clock) drains that FIFO one word per pop strobe.

## Interface
- `BASE_ADDR`, 24'h000000: word address of the first word of the frame.
- `FRAME_WORDS`, 9600: number of 32-bit words per frame; range 1..2^24-1.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, at least 2.

- `clk` in 1: system clock (CLOCK_50 domain).
- `rst` in 1: already decided as synchronous, active-high reset.
- `enable` in 1: permits new DRAM requests.
- `frame_start` in 1: one-cycle pulse; restarts fetch at `BASE_ADDR` and flushes the FIFO.
- `pix_pop` in 1: consumer takes `pix_data` this cycle.
- `pix_data` out 32: FIFO head word; valid while `pix_valid`.
- `pix_valid` out 1: FIFO not empty.
- `underflow` out 1: sticky; set when a pop occurs while the FIFO is empty.
- `frame_done` out 1: all `FRAME_WORDS` words have been fetched.
- `addr1` out 24: request address to the arbiter.
- `req_read1` out 1: read request to the arbiter.
- `data1` in 32: read data from the arbiter.
- `data_valid1` in 1: one-cycle strobe qualifying `data1`.

## Operation
- States:
  - IDLE: no request outstanding.
  - REQ: `req_read1` is high and `addr1` is stable.
  - GAP: one cycle with `req_read1` low.
  - DONE: frame complete.
- Arbiter handshake: `req_read1` and `addr1` are held constant until `data_valid1` is sampled high. At most one request is outstanding. `req_read1` is never withdrawn before `data_valid1`.
- IDLE → REQ when `enable`, `frame_done`=0, and `count + 1 <= FIFO_DEPTH`. There is always room reserved for the in-flight word.
- REQ → GAP on `data_valid1`:
  - The word is pushed into the FIFO unless a discard is pending.
  - The address increments by 1.
  - The words-remaining counter decrements.
- GAP → REQ under the same conditions as IDLE → REQ. Otherwise GAP → IDLE, or GAP → DONE when the remaining count reaches 0 (`frame_done`=1).
- `enable` low: no new request is issued. An in-flight request completes normally.
- `frame_start` in IDLE, GAP or DONE:
  - FIFO is flushed.
  - Address is set to `BASE_ADDR` and the remaining count to `FRAME_WORDS`.
  - `frame_done`=0 and `underflow`=0.
  - Next state is IDLE.
- `frame_start` in REQ: the flush and reload are applied immediately, but the request stays asserted (protocol). A discard flag is set. The returning word is dropped and the counters are not touched. Then GAP → normal restart from `BASE_ADDR`.
- FIFO: simultaneous push and pop leaves `count` unchanged. A push when full cannot occur by construction; the bench asserts this. A pop when empty is ignored and sets `underflow`.
- No address wrap. Fetching stops at `BASE_ADDR + FRAME_WORDS - 1` until the next `frame_start`.

## Timing
- Reset values: `req_read1`=0, `addr1`=`BASE_ADDR`, `pix_valid`=0, `pix_data`=0, `underflow`=0, `frame_done`=0, state IDLE, FIFO empty, remaining count=`FRAME_WORDS`.
- All outputs are registered, except `pix_data`/`pix_valid`, which come from FIFO registers (no combinational path from inputs).
- `enable` sampled high in IDLE at edge N → `req_read1` high after edge N.
- `data_valid1` at edge M:
  - `req_read1` is low after edge M.
  - `pix_valid` is high after edge M if the FIFO was empty.
- Peak request rate: one word per (arbiter latency + 2) cycles.
- `pix_pop` at edge K → the next word appears at `pix_data` after edge K.

## Structure
- Shared package `d16_bus_pkg`: `ADDR_W`=24, `DATA_W`=32, and the `fb_state_t` enum (IDLE, REQ, GAP, DONE).
- One sub-module, `fb_fifo`: synchronous FIFO, parameter `DEPTH`, ports push/pop/din/dout/count/empty/flush, first-word-fall-through.

## Test plan
- Reset, `enable`=1, `FRAME_WORDS`=4, arbiter model with 3-cycle latency returning `data=addr` → `pix_data` sequence 0,1,2,3; `frame_done`=1; exactly 4 `req_read1` rising edges; no fifth request.
- FIFO fill: `FIFO_DEPTH`=4, no pops, `FRAME_WORDS`=10 → requests stop with `count`=4. Popping one word issues exactly one new request.
- `frame_start` pulsed while REQ is pending at `addr1`=5 → `req_read1` stays high until `data_valid1`; that word is dropped; the next request is at `BASE_ADDR`; the FIFO is empty at the restart.
- Pop while empty → `underflow`=1 and it stays set; the following `frame_start` clears it.
- `enable` dropped mid-REQ → the current word is delivered; no further `req_read1` until `enable` returns.
- Reset asserted while REQ is pending → the next cycle shows `req_read1`=0 and all outputs at reset values; a stray `data_valid1` after reset pushes nothing.
